// File: rtl/sorted_array_tx_pkg.sv
// Shared definitions for the sorted-array serial transmitter: RAM geometry,
// default bit period, sequencing states and small address helpers.
package sorted_array_tx_pkg;

    localparam int DEPTH      = 16;
    localparam int AW         = 4;
    localparam int DW         = 8;
    localparam int DEF_DIV    = 5208;
    localparam int FRAME_BITS = 10;

    localparam logic [AW-1:0] ADDR_FIRST = AW'(0);
    localparam logic [AW-1:0] ADDR_LAST  = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_WAIT    = 3'd2,
        ST_START_B = 3'd3,
        ST_DATA_B  = 3'd4,
        ST_STOP_B  = 3'd5
    } state_t;

    // Next address in the selected walk order (modulo 2**AW).
    function automatic logic [AW-1:0] step_addr(input logic [AW-1:0] addr,
                                                input logic            desc);
        logic [AW-1:0] nxt;
        if (desc) begin
            nxt = addr - 1'b1;
        end else begin
            nxt = addr + 1'b1;
        end
        return nxt;
    endfunction

    // True when addr is the final word of the selected walk order.
    function automatic logic is_last_addr(input logic [AW-1:0] addr,
                                          input logic            desc);
        logic last;
        if (desc) begin
            last = (addr == ADDR_FIRST);
        end else begin
            last = (addr == ADDR_LAST);
        end
        return last;
    endfunction

endpackage

// File: rtl/sorted_array_tx_tx_frame.sv
// One UART 8N1 frame: loads a byte, drives start/data/stop bits of DIV clocks
// each on txd, and raises frame_done during the last clock of the stop bit so
// the sequencer can act on the very edge the stop bit ends.
module tx_frame
    import sorted_array_tx_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] data,
    output logic          txd,
    output logic          frame_done
);

    localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);
    localparam logic [DIVW-1:0] DIV_PRE  = DIVW'(DIV - 2);
    localparam logic [2:0]      BIT_LAST = 3'(DW - 1);

    state_t          phase_r;
    logic [DIVW-1:0] div_r;
    logic [2:0]      bit_r;
    logic [DW-1:0]   shift_r;
    logic            txd_r;
    logic            done_r;
    logic            div_end_s;

    // Divider wrap marks the end of the current bit period.
    always_comb begin
        div_end_s = 1'b0;
        if (div_r == DIV_LAST) begin
            div_end_s = 1'b1;
        end else begin
            div_end_s = 1'b0;
        end
    end

    // Bit-phase sequencing, divider, bit counter, shifter and serial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= ST_IDLE;
            div_r   <= {DIVW{1'b0}};
            bit_r   <= 3'd0;
            shift_r <= {DW{1'b0}};
            txd_r   <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            // Registered one clock early so it is high during the last stop clock.
            done_r <= (phase_r == ST_STOP_B) && (div_r == DIV_PRE);
            if (load) begin
                phase_r <= ST_START_B;
                shift_r <= data;
                txd_r   <= 1'b0;
                div_r   <= {DIVW{1'b0}};
                bit_r   <= 3'd0;
            end else begin
                case (phase_r)
                    ST_START_B: begin
                        if (div_end_s) begin
                            div_r   <= {DIVW{1'b0}};
                            txd_r   <= shift_r[0];
                            bit_r   <= 3'd0;
                            phase_r <= ST_DATA_B;
                        end else begin
                            div_r <= div_r + 1'b1;
                        end
                    end
                    ST_DATA_B: begin
                        if (div_end_s) begin
                            div_r <= {DIVW{1'b0}};
                            if (bit_r == BIT_LAST) begin
                                txd_r   <= 1'b1;
                                phase_r <= ST_STOP_B;
                            end else begin
                                shift_r <= shift_r >> 1;
                                txd_r   <= shift_r[1];
                                bit_r   <= bit_r + 1'b1;
                            end
                        end else begin
                            div_r <= div_r + 1'b1;
                        end
                    end
                    ST_STOP_B: begin
                        if (div_end_s) begin
                            div_r   <= {DIVW{1'b0}};
                            phase_r <= ST_IDLE;
                        end else begin
                            div_r <= div_r + 1'b1;
                        end
                    end
                    default: begin
                        phase_r <= ST_IDLE;
                        div_r   <= {DIVW{1'b0}};
                        txd_r   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign txd        = txd_r;
    assign frame_done = done_r;

endmodule

// File: rtl/sorted_array_tx.sv
// Reads all DEPTH words of the sort RAM in ascending or descending address
// order and sends each as a UART 8N1 frame. The sequencer walks RD -> WAIT ->
// frame for every word; tx_frame owns the bit timing.
module sorted_array_tx
    import sorted_array_tx_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic          C,
    input  logic          anR,
    input  logic          START,
    input  logic          DESC,
    input  logic [DW-1:0] RAMQ,
    output logic [AW-1:0] ADDRQ,
    output logic          TxDQ,
    output logic          BUSYQ,
    output logic          DONEQ
);

    // ST_START_B here means "a frame is in flight"; tx_frame walks the
    // start/data/stop phases itself.
    state_t        state_r;
    logic [AW-1:0] addr_r;
    logic          busy_r;
    logic          done_r;
    logic          desc_r;
    logic          load_r;
    logic          frame_done_s;
    logic          txd_s;

    // Address / pass sequencer with registered BUSY and DONE.
    always_ff @(posedge C or negedge anR) begin
        if (!anR) begin
            state_r <= ST_IDLE;
            addr_r  <= ADDR_FIRST;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            desc_r  <= 1'b0;
            load_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            load_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        addr_r  <= DESC ? ADDR_LAST : ADDR_FIRST;
                        desc_r  <= DESC;
                        busy_r  <= 1'b1;
                        state_r <= ST_RD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    // RAM samples ADDRQ at this edge; byte is valid during WAIT.
                    load_r  <= 1'b1;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // tx_frame captures RAMQ and drops the line at this edge.
                    state_r <= ST_START_B;
                end
                ST_START_B: begin
                    if (frame_done_s) begin
                        if (is_last_addr(addr_r, desc_r)) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            addr_r  <= step_addr(addr_r, desc_r);
                            state_r <= ST_RD;
                        end
                    end else begin
                        state_r <= ST_START_B;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    tx_frame #(
        .DIV(DIV)
    ) u_tx_frame (
        .clk       (C),
        .rst_n     (anR),
        .load      (load_r),
        .data      (RAMQ),
        .txd       (txd_s),
        .frame_done(frame_done_s)
    );

    assign ADDRQ = addr_r;
    assign TxDQ  = txd_s;
    assign BUSYQ = busy_r;
    assign DONEQ = done_r;

endmodule

// File: tb/tb_sorted_array_tx.sv
// Self-checking bench for sorted_array_tx with DIV=4 and a 1-clock registered
// RAM. A behavioural model derives every output from the cycle offset since
// the accepting edge; a UART decoder and literal checks pin the model.
module tb_sorted_array_tx;

    localparam int D  = 4;
    localparam int N  = 16;
    localparam int FR = 10 * D + 2;
    localparam int L  = N * FR;
    localparam int LOGN = 20000;

    logic       C = 1'b0;
    logic       anR = 1'b0;
    logic       START = 1'b0;
    logic       DESC = 1'b0;
    logic [7:0] RAMQ;
    logic [3:0] ADDRQ;
    logic       TxDQ, BUSYQ, DONEQ;

    sorted_array_tx #(.DIV(D)) dut (
        .C(C), .anR(anR), .START(START), .DESC(DESC), .RAMQ(RAMQ),
        .ADDRQ(ADDRQ), .TxDQ(TxDQ), .BUSYQ(BUSYQ), .DONEQ(DONEQ)
    );

    always #5 C = ~C;

    logic [7:0] mem [0:N-1];
    always @(posedge C) RAMQ <= mem[ADDRQ];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit tx_log [0:LOGN-1];

    always @(posedge C) cyc <= cyc + 1;
    always @(negedge C) if (cyc < LOGN) tx_log[cyc] <= TxDQ;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_active = 1'b0;
    int         m_k = 0;
    bit         m_desc = 1'b0;
    logic [3:0] m_last = 4'd0;
    int         acc_cyc = 0;
    int         pass_cnt = 0;

    always @(posedge C or negedge anR) begin
        if (!anR) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_last   <= 4'd0;
        end else if (m_active && m_k < L) begin
            m_k <= m_k + 1;
        end else if (START) begin
            m_active <= 1'b1;
            m_k      <= 0;
            m_desc   <= DESC;
            acc_cyc  <= cyc + 1;
            pass_cnt <= pass_cnt + 1;
        end else if (m_active) begin
            m_active <= 1'b0;
            m_last   <= m_desc ? 4'd0 : 4'd15;
        end
    end

    // Serial level k clocks after the accepting edge.
    function automatic bit exp_tx(input int k, input bit desc);
        int t, f, r;
        logic [7:0] b;
        if (k < 2) return 1'b1;
        t = k - 2;
        f = t / FR;
        r = t % FR;
        if (f >= N) return 1'b1;
        if (r < D) return 1'b0;
        if (r < 9 * D) begin
            b = mem[desc ? (N - 1 - f) : f];
            return b[(r - D) / D];
        end
        return 1'b1;
    endfunction

    function automatic int exp_addr(input int k, input bit desc);
        int f;
        f = k / FR;
        if (f > N - 1) f = N - 1;
        return desc ? (N - 1 - f) : f;
    endfunction

    bit cmp_en = 1'b0;

    // Per-cycle comparison of every output against the model.
    always @(negedge C) begin
        if (cmp_en) begin
            if (m_active) begin
                chk("txd",  TxDQ,  exp_tx(m_k, m_desc));
                chk("busy", BUSYQ, (m_k < L) ? 1 : 0);
                chk("done", DONEQ, (m_k == L) ? 1 : 0);
                chk("addr", ADDRQ, exp_addr(m_k, m_desc));
            end else begin
                chk("idle_txd",  TxDQ,  1);
                chk("idle_busy", BUSYQ, 0);
                chk("idle_done", DONEQ, 0);
                chk("idle_addr", ADDRQ, m_last);
            end
        end
    end

    int done_cnt = 0;
    int done_cyc = 0;
    always @(negedge C) begin
        if (DONEQ) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    // ---------------- UART decoder over the line log ----------------
    logic [7:0] dec_b   [0:39];
    int         dec_gap [0:39];
    int         dec_n;

    task automatic decode(input int from, input int to);
        int run;
        logic [7:0] b;
        run = 0;
        dec_n = 0;
        for (int t = from; t < to && t < LOGN - 10 * D; t++) begin
            if (tx_log[t] == 1'b1) begin
                run++;
            end else if (run > 0) begin
                for (int i = 0; i < 8; i++) b[i] = tx_log[t + D * (i + 1) + D / 2];
                if (dec_n < 40) begin
                    dec_b[dec_n]   = b;
                    dec_gap[dec_n] = run;
                end
                dec_n++;
                t = t + 9 * D - 1;
                run = 0;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_active && n < L + 100) begin
            @(negedge C);
            n++;
        end
        chk("pass_timeout", m_active, 0);
        chk("busy_after_pass", BUSYQ, 0);
    endtask

    task automatic wait_cyc(input int target);
        int n;
        n = 0;
        while (cyc < target && n < 2 * L) begin
            @(negedge C);
            n++;
        end
    endtask

    task automatic pulse_start(input bit desc);
        @(negedge C);
        START = 1'b1;
        DESC  = desc;
        @(negedge C);
        START = 1'b0;
        DESC  = $urandom_range(1, 0);
    endtask

    task automatic check_frames(input string nm, input bit desc);
        chk({nm, "_nframes"}, dec_n, N);
        for (int i = 0; i < N; i++)
            chk({nm, "_byte"}, dec_b[i], desc ? ((N - 1 - i) * 16 + 1) : (i * 16 + 1));
    endtask

    int pat [0:7] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int d0, p0, a1, a2, d1;

    initial begin
        for (int i = 0; i < N; i++) mem[i] = 8'(i * 16 + 1);
        repeat (3) @(negedge C);
        chk("rst_txd",  TxDQ,  1);
        chk("rst_busy", BUSYQ, 0);
        chk("rst_done", DONEQ, 0);
        chk("rst_addr", ADDRQ, 0);
        cmp_en = 1'b1;
        @(negedge C);
        anR = 1'b1;
        repeat (3) @(negedge C);

        // Ascending pass
        d0 = done_cnt;
        pulse_start(1'b0);
        wait_idle();
        chk("asc_k1_high", tx_log[acc_cyc + 1], 1);
        chk("asc_k2_low",  tx_log[acc_cyc + 2], 0);
        decode(acc_cyc, acc_cyc + L);
        chk("asc_first_byte", dec_b[0], 8'h01);
        chk("asc_second_byte", dec_b[1], 8'h11);
        check_frames("asc", 1'b0);
        chk("asc_done_count", done_cnt - d0, 1);
        chk("asc_done_at", done_cyc - acc_cyc, 672);

        // Descending pass
        repeat ($urandom_range(5, 1)) @(negedge C);
        pulse_start(1'b1);
        wait_idle();
        decode(acc_cyc, acc_cyc + L);
        chk("desc_first_byte", dec_b[0], 8'hF1);
        chk("desc_last_byte", dec_b[15], 8'h01);
        check_frames("desc", 1'b1);
        chk("desc_final_addr", ADDRQ, 0);

        // Bit timing on a 0xA5 first frame
        mem[0] = 8'hA5;
        pulse_start(1'b0);
        wait_idle();
        for (int k = 2; k < 6; k++) chk("a5_start_bit", tx_log[acc_cyc + k], 0);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < D; j++)
                chk("a5_data_bit", tx_log[acc_cyc + 6 + 4 * i + j], pat[i]);
        for (int k = 38; k < 44; k++) chk("a5_stop_gap", tx_log[acc_cyc + k], 1);
        chk("a5_next_start", tx_log[acc_cyc + 44], 0);
        mem[0] = 8'h01;

        // START pulses while busy are ignored
        d0 = done_cnt;
        p0 = pass_cnt;
        pulse_start(1'b0);
        a1 = acc_cyc;
        wait_cyc(a1 + 2 + 5 * FR + 8);
        START = 1'b1;
        DESC  = 1'b1;
        repeat (2) @(negedge C);
        START = 1'b0;
        wait_idle();
        decode(a1, a1 + L);
        check_frames("busy_start", 1'b0);
        chk("busy_start_done", done_cnt - d0, 1);
        chk("busy_start_accepts", pass_cnt - p0, 1);

        // Asynchronous reset in the middle of frame 7 data bits
        pulse_start(1'b0);
        wait_cyc(acc_cyc + 2 + 7 * FR + D + 10);
        chk("pre_rst_txd", TxDQ, 0);
        #2 anR = 1'b0;
        #1;
        chk("async_rst_txd",  TxDQ,  1);
        chk("async_rst_busy", BUSYQ, 0);
        repeat (2) @(negedge C);
        anR = 1'b1;
        repeat (2) @(negedge C);
        pulse_start(1'b0);
        wait_idle();
        decode(acc_cyc, acc_cyc + L);
        chk("post_rst_first", dec_b[0], 8'h01);
        check_frames("post_rst", 1'b0);

        // START held high: back-to-back passes
        p0 = pass_cnt;
        @(negedge C);
        START = 1'b1;
        DESC  = 1'b0;
        wait_cyc(cyc + 2);
        a1 = acc_cyc;
        begin
            int n;
            n = 0;
            while (pass_cnt < p0 + 2 && n < L + 100) begin
                @(negedge C);
                n++;
            end
        end
        a2 = acc_cyc;
        d1 = done_cyc;
        START = 1'b0;
        chk("held_two_passes", pass_cnt - p0, 2);
        chk("held_restart_after_done", a2 - d1, 1);
        chk("held_pass_period", a2 - a1, L + 1);
        wait_idle();
        decode(a1, a2 + L);
        chk("held_nframes", dec_n, 2 * N);
        chk("held_frame_gap", dec_gap[1], D + 2);
        chk("held_pass_gap", dec_gap[16], D + 3);
        chk("held_pass2_first", dec_b[16], 8'h01);

        repeat (3) @(negedge C);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
